// File: rtl/wbu_commit.sv
// Write-back / commit stage: retires one LSU result at a time, writes GPR/CSR,
// handles ecall/mret trap bookkeeping and hands the next PC back to the IFU.
module wbu_commit #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter logic [31:0] ECALL_CODE = 32'd11
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        valid_in_lsu,
    output logic        ready_out_lsu,
    input  logic        ben,
    input  logic        is_ecall,
    input  logic        is_mret,
    input  logic [31:0] pc,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic        gpr_wen,
    input  logic [31:0] alu_out,
    input  logic [31:0] rdata,
    input  logic [31:0] csr_out,
    input  logic        csr_wen,
    input  logic [11:0] csr_waddr,
    input  logic [31:0] csr_wdata,
    input  logic [31:0] jmp_target,

    output logic        gpr_we,
    output logic [4:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,
    output logic        csr_we,
    output logic [11:0] csr_wa,
    output logic [31:0] csr_wd,

    output logic        valid_out_ifu,
    input  logic        ready_in_ifu,
    output logic [31:0] next_pc,
    output logic [63:0] retire_cnt
);

    localparam logic [2:0] S_BOOT     = 3'd0;
    localparam logic [2:0] S_IDLE     = 3'd1;
    localparam logic [2:0] S_COMMIT   = 3'd2;
    localparam logic [2:0] S_TRAP     = 3'd3;
    localparam logic [2:0] S_REDIRECT = 3'd4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    logic [2:0]  state;
    logic [2:0]  state_nxt;

    logic        l_ben;
    logic        l_ecall;
    logic        l_mret;
    logic [31:0] l_pc;
    logic [6:0]  l_opcode;
    logic [4:0]  l_rd;
    logic        l_gpr_wen;
    logic [31:0] l_alu_out;
    logic [31:0] l_rdata;
    logic [31:0] l_csr_out;
    logic        l_csr_wen;
    logic [11:0] l_csr_waddr;
    logic [31:0] l_csr_wdata;
    logic [31:0] l_jmp_target;

    logic        in_boot;
    logic        in_idle;
    logic        in_commit;
    logic        in_trap;
    logic        in_redirect;
    logic        lsu_fire;
    logic        ifu_fire;

    logic        is_load;
    logic        is_jal;
    logic        is_jalr;
    logic        is_system;
    logic [31:0] pc_plus4;
    logic [31:0] wb_data;
    logic [31:0] npc_commit;

    assign in_boot     = (state == S_BOOT);
    assign in_idle     = (state == S_IDLE);
    assign in_commit   = (state == S_COMMIT);
    assign in_trap     = (state == S_TRAP);
    assign in_redirect = (state == S_REDIRECT);

    assign lsu_fire = in_idle & valid_in_lsu;
    assign ifu_fire = (in_boot | in_redirect) & ready_in_ifu;

    assign is_load   = (l_opcode == OP_LOAD);
    assign is_jal    = (l_opcode == OP_JAL);
    assign is_jalr   = (l_opcode == OP_JALR);
    assign is_system = (l_opcode == OP_SYSTEM);
    assign pc_plus4  = l_pc + 32'd4;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_BOOT:     if (ready_in_ifu) state_nxt = S_IDLE;
            S_IDLE:     if (valid_in_lsu) state_nxt = S_COMMIT;
            S_COMMIT:   state_nxt = l_ecall ? S_TRAP : S_REDIRECT;
            S_TRAP:     state_nxt = S_REDIRECT;
            S_REDIRECT: if (ready_in_ifu) state_nxt = S_IDLE;
            default:    state_nxt = S_BOOT;
        endcase
    end

    always_comb begin
        wb_data = l_alu_out;
        unique case (1'b1)
            is_load:           wb_data = l_rdata;
            is_jal, is_jalr:   wb_data = pc_plus4;
            is_system:         wb_data = l_csr_out;
            default:           wb_data = l_alu_out;
        endcase
    end

    // Trap entry/return take precedence over any control-flow target.
    always_comb begin
        if (l_ecall || l_mret)
            npc_commit = l_csr_out;
        else if (is_jalr)
            npc_commit = l_jmp_target & ~32'd1;
        else if (is_jal || l_ben)
            npc_commit = l_jmp_target;
        else
            npc_commit = pc_plus4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_BOOT;
            next_pc    <= RESET_PC;
            retire_cnt <= 64'd0;
        end else begin
            state <= state_nxt;
            if (in_commit) begin
                next_pc    <= npc_commit;
                retire_cnt <= retire_cnt + 64'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_ben        <= 1'b0;
            l_ecall      <= 1'b0;
            l_mret       <= 1'b0;
            l_pc         <= 32'd0;
            l_opcode     <= 7'd0;
            l_rd         <= 5'd0;
            l_gpr_wen    <= 1'b0;
            l_alu_out    <= 32'd0;
            l_rdata      <= 32'd0;
            l_csr_out    <= 32'd0;
            l_csr_wen    <= 1'b0;
            l_csr_waddr  <= 12'd0;
            l_csr_wdata  <= 32'd0;
            l_jmp_target <= 32'd0;
        end else if (lsu_fire) begin
            l_ben        <= ben;
            l_ecall      <= is_ecall;
            l_mret       <= is_mret;
            l_pc         <= pc;
            l_opcode     <= opcode;
            l_rd         <= rd;
            l_gpr_wen    <= gpr_wen;
            l_alu_out    <= alu_out;
            l_rdata      <= rdata;
            l_csr_out    <= csr_out;
            l_csr_wen    <= csr_wen;
            l_csr_waddr  <= csr_waddr;
            l_csr_wdata  <= csr_wdata;
            l_jmp_target <= jmp_target;
        end
    end

    assign ready_out_lsu = in_idle;
    assign valid_out_ifu = in_boot | in_redirect;

    assign gpr_we    = in_commit & l_gpr_wen & (l_rd != 5'd0);
    assign gpr_waddr = l_rd;
    assign gpr_wdata = wb_data;

    // ecall overrides the instruction's own CSR write with the mepc save.
    always_comb begin
        csr_we = 1'b0;
        csr_wa = l_csr_waddr;
        csr_wd = l_csr_wdata;
        if (in_commit) begin
            if (l_ecall) begin
                csr_we = 1'b1;
                csr_wa = CSR_MEPC;
                csr_wd = l_pc;
            end else begin
                csr_we = l_csr_wen;
            end
        end else if (in_trap) begin
            csr_we = 1'b1;
            csr_wa = CSR_MCAUSE;
            csr_wd = ECALL_CODE;
        end
    end

    logic unused_ok;
    assign unused_ok = ifu_fire;

endmodule
